// File: rtl/strassen_seq_ctrl.sv
// Strassen tile sequencer: steps each 2x2 tile through PRE, MULT, POST and WRITE,
// runs multi-tile jobs with a start/done handshake and stalls on memory back-pressure.
module strassen_seq_ctrl #(
  parameter int unsigned NUM_ALU   = 10,
  parameter int unsigned NUM_MUX   = 4,
  parameter int unsigned ALU_OP_W  = 3,
  parameter int unsigned MUX_SEL_W = 2,
  parameter int unsigned BLK_W     = 8,
  parameter logic [NUM_ALU-1:0] PRE_SUB_MASK  = NUM_ALU'(10'h158),
  parameter logic [NUM_ALU-1:0] POST_SUB_MASK = NUM_ALU'(10'h018)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [BLK_W-1:0]               blk_cnt_i,
  input  logic                           mem_ready_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [BLK_W-1:0]               blk_idx_o,
  output logic [NUM_ALU*ALU_OP_W-1:0]    alu_op_o,
  output logic [NUM_MUX*MUX_SEL_W-1:0]   mux_sel_o,
  output logic                           mem_we_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StMult  = 3'd2;
  localparam logic [2:0] StPost  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [ALU_OP_W-1:0] OpAdd = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OpSub = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OpMul = ALU_OP_W'(2);

  localparam int unsigned SelMax = (1 << MUX_SEL_W) - 1;

  logic [2:0]       state_q, state_d;
  logic [BLK_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] idx_q, idx_d;

  // Next-state: job acceptance, stage sequencing and tile stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d   = blk_cnt_i;
          idx_d   = '0;
          state_d = (blk_cnt_i != '0) ? StPre : StDone;
        end
      end
      StPre:  state_d = StMult;
      StMult: state_d = StPost;
      StPost: if (mem_ready_i) state_d = StWrite;
      StWrite: begin
        if (mem_ready_i) begin
          // Compare against count-1 so a full-scale count never wraps the index.
          if (idx_q == cnt_q - BLK_W'(1)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + BLK_W'(1);
            state_d = StPre;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign blk_idx_o = idx_q;

  // Moore output decode: opcodes, write enable and staged mux selects.
  always_comb begin
    int unsigned stage;
    int unsigned sel;
    logic        staged;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    mem_we_o  = 1'b0;
    alu_op_o  = '0;
    mux_sel_o = '0;
    stage     = 0;
    sel       = 0;
    staged    = 1'b0;
    case (state_q)
      StPre: begin
        busy_o = 1'b1;
        staged = 1'b1;
        stage  = 0;
        for (int unsigned i = 0; i < NUM_ALU; i++) begin
          alu_op_o[i*ALU_OP_W +: ALU_OP_W] = PRE_SUB_MASK[i] ? OpSub : OpAdd;
        end
      end
      StMult: begin
        busy_o = 1'b1;
        staged = 1'b1;
        stage  = 1;
        for (int unsigned i = 0; i < NUM_ALU; i++) begin
          alu_op_o[i*ALU_OP_W +: ALU_OP_W] = OpMul;
        end
      end
      StPost: begin
        busy_o   = 1'b1;
        mem_we_o = 1'b1;
        staged   = 1'b1;
        stage    = 2;
        for (int unsigned i = 0; i < NUM_ALU; i++) begin
          alu_op_o[i*ALU_OP_W +: ALU_OP_W] = POST_SUB_MASK[i] ? OpSub : OpAdd;
        end
      end
      StWrite: begin
        busy_o   = 1'b1;
        mem_we_o = 1'b1;
        staged   = 1'b1;
        stage    = 3;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
    if (staged) begin
      // Mux k only advances up to its own depth in the tree.
      for (int unsigned k = 0; k < NUM_MUX; k++) begin
        sel = (stage < k) ? stage : k;
        if (sel > SelMax) sel = SelMax;
        mux_sel_o[k*MUX_SEL_W +: MUX_SEL_W] = MUX_SEL_W'(sel);
      end
    end
  end

endmodule

// File: tb/tb_strassen_seq_ctrl.sv
// Bench for strassen_seq_ctrl: directed steps plus randomized jobs against a stage-level model.
module tb_strassen_seq_ctrl;

  localparam logic [63:0] PreM  = 64'h158;
  localparam logic [63:0] PostM = 64'h018;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  blk_cnt;
  logic        mem_ready;
  logic        busy, done, mem_we;
  logic [7:0]  blk_idx;
  logic [29:0] alu_op;
  logic [7:0]  mux_sel;

  logic        s_start;
  logic [7:0]  s_blk_cnt;
  logic        s_ready;
  logic        s_busy, s_done, s_we;
  logic [7:0]  s_idx;
  logic [11:0] s_alu;
  logic [3:0]  s_mux;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  strassen_seq_ctrl u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .blk_cnt_i  (blk_cnt),
    .mem_ready_i(mem_ready),
    .busy_o     (busy),
    .done_o     (done),
    .blk_idx_o  (blk_idx),
    .alu_op_o   (alu_op),
    .mux_sel_o  (mux_sel),
    .mem_we_o   (mem_we)
  );

  strassen_seq_ctrl #(
    .NUM_ALU      (4),
    .NUM_MUX      (2),
    .PRE_SUB_MASK (4'b1010),
    .POST_SUB_MASK(4'b1000)
  ) u_small (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (s_start),
    .blk_cnt_i  (s_blk_cnt),
    .mem_ready_i(s_ready),
    .busy_o     (s_busy),
    .done_o     (s_done),
    .blk_idx_o  (s_idx),
    .alu_op_o   (s_alu),
    .mux_sel_o  (s_mux),
    .mem_we_o   (s_we)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected opcodes for stage s (0..3): SUB where the stage mask bit is set, MULT in stage 1.
  function automatic logic [63:0] exp_alu(input int s, input int nalu,
                                          input logic [63:0] pre, input logic [63:0] post);
    logic [63:0] r;
    logic [2:0]  op;
    r = '0;
    for (int i = 0; i < nalu; i++) begin
      case (s)
        0:       op = pre[i]  ? 3'd1 : 3'd0;
        1:       op = 3'd2;
        2:       op = post[i] ? 3'd1 : 3'd0;
        default: op = 3'd0;
      endcase
      r[i*3 +: 3] = op;
    end
    return r;
  endfunction

  // Expected selects: min(stage, k) clamped to 3.
  function automatic logic [63:0] exp_mux(input int s, input int nmux);
    logic [63:0] r;
    int v;
    r = '0;
    for (int k = 0; k < nmux; k++) begin
      v = (s < k) ? s : k;
      if (v > 3) v = 3;
      r[k*2 +: 2] = 2'(v);
    end
    return r;
  endfunction

  task automatic check_quiet(input string tag, input logic exp_done, input logic [63:0] exp_idx);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'(exp_done));
    check({tag, " idx"}, 64'(blk_idx), exp_idx);
    check({tag, " alu"}, 64'(alu_op), 64'd0);
    check({tag, " mux"}, 64'(mux_sel), 64'd0);
    check({tag, " we"}, 64'(mem_we), 64'd0);
  endtask

  // mode: 0 no stalls, 1 random stalls, 2 three stalls in POST of tile 0, 3 start pulse in MULT.
  task automatic run_job(input int n, input int mode, output int lat, output int we_cnt);
    bit r;
    bit adv;
    int held;
    lat = 0;
    we_cnt = 0;
    start = 1'b1;
    blk_cnt = 8'(n);
    mem_ready = 1'b1;
    step();
    start = 1'b0;
    blk_cnt = 8'($urandom);
    for (int t = 0; t < n; t++) begin
      for (int s = 0; s < 4; s++) begin
        adv = 1'b0;
        held = 0;
        while (!adv) begin
          check($sformatf("t%0d s%0d busy", t, s), 64'(busy), 64'd1);
          check($sformatf("t%0d s%0d done", t, s), 64'(done), 64'd0);
          check($sformatf("t%0d s%0d idx", t, s), 64'(blk_idx), 64'(t));
          check($sformatf("t%0d s%0d alu", t, s), 64'(alu_op), exp_alu(s, 10, PreM, PostM));
          check($sformatf("t%0d s%0d mux", t, s), 64'(mux_sel), exp_mux(s, 4));
          check($sformatf("t%0d s%0d we", t, s), 64'(mem_we), 64'(s >= 2));
          if (busy) lat++;
          if (mem_we) we_cnt++;
          r = 1'b1;
          if (mode == 1) r = (s < 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
          if (mode == 1 && held >= 6) r = 1'b1;
          if (mode == 2 && t == 0 && s == 2 && held < 3) r = 1'b0;
          if (mode == 3 && t == 0 && s == 1) begin
            start = 1'b1;
            blk_cnt = 8'd7;
          end
          mem_ready = r;
          step();
          start = 1'b0;
          if (s < 2 || r) adv = 1'b1;
          else held++;
        end
      end
    end
    mem_ready = 1'b1;
    check_quiet("job done", 1'b1, 64'(n - 1));
    step();
    check_quiet("job idle", 1'b0, 64'(n - 1));
  endtask

  initial begin
    int lat;
    int wec;
    rst_n = 1'b1;
    start = 1'b0;
    blk_cnt = '0;
    mem_ready = 1'b1;
    s_start = 1'b0;
    s_blk_cnt = '0;
    s_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_quiet("reset", 1'b0, 64'd0);
    step();
    #3 rst_n = 1'b1;
    step();
    check_quiet("post reset", 1'b0, 64'd0);

    // Single tile, then three tiles with no stalls.
    run_job(1, 0, lat, wec);
    check("lat1", 64'(lat), 64'd4);
    run_job(3, 0, lat, wec);
    check("lat3", 64'(lat), 64'd12);
    check("we3", 64'(wec), 64'd6);

    // Three back-pressure cycles in POST of tile 0.
    run_job(2, 2, lat, wec);
    check("lat stall", 64'(lat), 64'd11);

    // Start pulse during MULT is ignored.
    run_job(2, 3, lat, wec);
    check("lat ignore", 64'(lat), 64'd8);

    // Zero-tile job: done straight away, never busy.
    start = 1'b1;
    blk_cnt = 8'd0;
    step();
    start = 1'b0;
    check("zero busy", 64'(busy), 64'd0);
    check("zero done", 64'(done), 64'd1);
    step();
    check("zero busy2", 64'(busy), 64'd0);
    check("zero done2", 64'(done), 64'd0);

    // Asynchronous reset in MULT of tile 1.
    start = 1'b1;
    blk_cnt = 8'd2;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre-rst alu", 64'(alu_op), exp_alu(1, 10, PreM, PostM));
    check("pre-rst idx", 64'(blk_idx), 64'd1);
    #3 rst_n = 1'b0;
    #1 check_quiet("async rst", 1'b0, 64'd0);
    step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("after rst %0d done", i), 64'(done), 64'd0);
      check($sformatf("after rst %0d busy", i), 64'(busy), 64'd0);
    end
    run_job(1, 0, lat, wec);
    check("lat after rst", 64'(lat), 64'd4);

    // Randomized jobs with random back-pressure.
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 6), 1, lat, wec);
    end

    // Full-scale count completes without wrapping.
    run_job(255, 0, lat, wec);
    check("lat255", 64'(lat), 64'd1020);

    // Reduced-width instance.
    s_start = 1'b1;
    s_blk_cnt = 8'd1;
    step();
    s_start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("small s%0d alu", s), 64'(s_alu), exp_alu(s, 4, 64'hA, 64'h8));
      check($sformatf("small s%0d mux", s), 64'(s_mux), exp_mux(s, 2));
      check($sformatf("small s%0d we", s), 64'(s_we), 64'(s >= 2));
      check($sformatf("small s%0d busy", s), 64'(s_busy), 64'd1);
      step();
    end
    check("small done", 64'(s_done), 64'd1);
    check("small idx", 64'(s_idx), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
